// File: rtl/sv_seq_pkg.sv
// Shared types and default sizes for the select/validate pulse sequencer.
package sv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    GAP      = 3'd2,
    VALIDATE = 3'd3,
    WAIT_ACK = 3'd4,
    DONE     = 3'd5
  } seq_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ITER_W = 8;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_TMO_W  = 16;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that saturates at zero and flags when it is there.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement so a reload in the same cycle always takes effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/select_validate_sequencer.sv
// Per-iteration select / gap / validate / ack-wait sequencer with sticky per-channel
// timeout flags; all outputs are flopped one cycle behind the state that produces them.
module select_validate_sequencer
  import sv_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ITER_W = DEF_ITER_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [ITER_W-1:0] num_iter,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [TMO_W-1:0]  tmo_cycles,
  input  logic [NUM_CH-1:0] val_done,
  output logic [NUM_CH-1:0] select_test,
  output logic [NUM_CH-1:0] validate,
  output logic [ITER_W-1:0] iter_idx,
  output logic              busy,
  output logic              run_done,
  output logic [NUM_CH-1:0] timeout_err
);

  seq_state_t        state, state_nxt;
  logic [NUM_CH-1:0] ch_en_q;
  logic [ITER_W-1:0] num_iter_q;
  logic [GAP_W-1:0]  gap_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [NUM_CH-1:0] ack_q;
  logic              first_wait;
  logic              gap_zero, tmo_zero;
  logic [NUM_CH-1:0] ack_now;
  logic              all_acked, tmo_hit, last_iter, wait_exit;

  // The first WAIT_ACK cycle coincides with the validate pulse, so acks then are ignored.
  assign ack_now   = ack_q | (val_done & ch_en_q & {NUM_CH{~first_wait}});
  assign all_acked = ((ack_now & ch_en_q) == ch_en_q);
  assign tmo_hit   = (tmo_q != '0) && tmo_zero;
  assign last_iter = (iter_idx == (num_iter_q - ITER_W'(1)));
  assign wait_exit = all_acked || tmo_hit;

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == SELECT),
    .load_val (gap_q - GAP_W'(1)),
    .en       (state == GAP),
    .zero     (gap_zero)
  );

  seq_down_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == VALIDATE),
    .load_val (tmo_q - TMO_W'(1)),
    .en       (state == WAIT_ACK),
    .zero     (tmo_zero)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = ((num_iter == '0) || (ch_en == '0)) ? DONE : SELECT;
      SELECT:   state_nxt = (gap_q == '0) ? VALIDATE : GAP;
      GAP:      if (gap_zero) state_nxt = VALIDATE;
      VALIDATE: state_nxt = WAIT_ACK;
      WAIT_ACK: if (wait_exit) state_nxt = last_iter ? DONE : SELECT;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // busy follows the next state so it drops in the same cycle run_done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch_en_q     <= '0;
      num_iter_q  <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      ack_q       <= '0;
      first_wait  <= 1'b0;
      select_test <= '0;
      validate    <= '0;
      iter_idx    <= '0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      timeout_err <= '0;
    end else begin
      state       <= state_nxt;
      select_test <= (state == SELECT) ? ch_en_q : '0;
      validate    <= (state == VALIDATE) ? ch_en_q : '0;
      run_done    <= (state == DONE);
      busy        <= (state_nxt != IDLE);
      first_wait  <= (state == VALIDATE);
      case (state)
        IDLE: begin
          if (start) begin
            ch_en_q     <= ch_en;
            num_iter_q  <= num_iter;
            gap_q       <= gap_cycles;
            tmo_q       <= tmo_cycles;
            ack_q       <= '0;
            iter_idx    <= '0;
            timeout_err <= '0;
          end
        end
        VALIDATE: ack_q <= '0;
        WAIT_ACK: begin
          ack_q <= ack_now;
          if (wait_exit) begin
            if (!all_acked) timeout_err <= timeout_err | (ch_en_q & ~ack_now);
            if (!last_iter) iter_idx <= iter_idx + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_select_validate_sequencer.sv
// Self-checking bench: directed table, mid-run reset and random runs, each compared
// against an event-timeline model of when pulses, run_done and timeout flags occur.
module tb_select_validate_sequencer;

  localparam int VDN   = 2048;
  localparam int NEVER = 15;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  ch_en, val_done;
  logic [7:0]  num_iter, gap_cycles;
  logic [15:0] tmo_cycles;
  logic [3:0]  select_test, validate, timeout_err;
  logic [7:0]  iter_idx;
  logic        busy, run_done;

  select_validate_sequencer #(
    .NUM_CH(4), .ITER_W(8), .GAP_W(8), .TMO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_en(ch_en), .num_iter(num_iter),
    .gap_cycles(gap_cycles), .tmo_cycles(tmo_cycles), .val_done(val_done),
    .select_test(select_test), .validate(validate), .iter_idx(iter_idx),
    .busy(busy), .run_done(run_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [7:0]  n;
    logic [7:0]  gap;
    logic [15:0] tmo;
    logic [15:0] dly;
    logic [3:0]  noise;
    logic [7:0]  poke;
    logic [7:0]  exp_pulses;
    logic [3:0]  exp_err;
  } run_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;
  bit mon_on = 1'b0;

  logic [3:0] vd [VDN];
  int   exp_sel_c[$], exp_sel_it[$], exp_val_c[$];
  int   exp_done;
  logic [3:0] exp_err;
  int   sel_c[$], sel_it[$], val_c[$], done_c[$];
  logic [3:0] sel_v[$], val_v[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (select_test != 4'h0) begin
        sel_c.push_back(cyc - base); sel_v.push_back(select_test); sel_it.push_back(int'(iter_idx));
      end
      if (validate != 4'h0) begin
        val_c.push_back(cyc - base); val_v.push_back(validate);
      end
      if (run_done) done_c.push_back(cyc - base);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: start is seen in relative cycle 0, so the first select pulse lands
  // in cycle 2 and each later event is placed from the previous exit by counting.
  function automatic void plan(input run_t r);
    int t, v, c, d;
    logic [3:0] acc, err;
    exp_sel_c.delete(); exp_sel_it.delete(); exp_val_c.delete();
    for (int i = 0; i < VDN; i++) vd[i] = 4'($urandom) & r.noise;
    err = 4'h0;
    t = 1;
    if (r.n != 0 && r.en != 0) begin
      for (int k = 0; k < int'(r.n); k++) begin
        exp_sel_c.push_back(t + 1);
        exp_sel_it.push_back(k);
        v = t + int'(r.gap) + 2;
        exp_val_c.push_back(v);
        for (int ch = 0; ch < 4; ch++) begin
          d = int'(r.dly[ch*4 +: 4]);
          if (d != NEVER && v + d < VDN) vd[v+d][ch] = 1'b1;
        end
        acc = 4'h0;
        c = v;
        while (c < VDN - 1) begin
          if (c > v) acc = acc | (vd[c] & r.en);
          if ((acc & r.en) == r.en) break;
          if (r.tmo != 0 && c == v + int'(r.tmo) - 1) begin
            err = err | (r.en & ~acc);
            break;
          end
          c++;
        end
        t = c + 1;
      end
    end
    exp_done = t + 1;
    exp_err  = err;
  endfunction

  task automatic clearMon();
    sel_c.delete(); sel_v.delete(); sel_it.delete();
    val_c.delete(); val_v.delete(); done_c.delete();
  endtask

  task automatic startRun(input run_t r);
    plan(r);
    clearMon();
    @(posedge clk); #1;
    base = cyc; mon_on = 1'b1;
    ch_en = r.en; num_iter = r.n; gap_cycles = r.gap; tmo_cycles = r.tmo;
    start = 1'b1; val_done = vd[0];
  endtask

  task automatic applyStimulus(input run_t r, input string name, input bit use_tbl);
    int rel;
    startRun(r);
    for (int i = 0; i < exp_done + 4; i++) begin
      @(posedge clk); #1;
      rel = cyc - base;
      start = (r.poke != 0) && (rel == int'(r.poke));
      ch_en = 4'($urandom); num_iter = 8'($urandom);
      gap_cycles = 8'($urandom); tmo_cycles = 16'($urandom);
      val_done = (rel < VDN) ? vd[rel] : 4'h0;
      if (rel == 1) begin
        checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
        checkOutput({name, " err cleared"}, 32'(timeout_err), 32'd0);
      end
      if (rel == exp_done - 1) checkOutput({name, " busy before done"}, 32'(busy), 32'd1);
      if (rel == exp_done) checkOutput({name, " busy at done"}, 32'(busy), 32'd0);
    end
    mon_on = 1'b0;
    checkOutput({name, " sel count"}, 32'(sel_c.size()), 32'(exp_sel_c.size()));
    for (int i = 0; i < sel_c.size() && i < exp_sel_c.size(); i++) begin
      checkOutput($sformatf("%s sel%0d cycle", name, i), 32'(sel_c[i]), 32'(exp_sel_c[i]));
      checkOutput($sformatf("%s sel%0d value", name, i), 32'(sel_v[i]), 32'(r.en));
      checkOutput($sformatf("%s sel%0d iter", name, i), 32'(sel_it[i]), 32'(exp_sel_it[i]));
    end
    checkOutput({name, " val count"}, 32'(val_c.size()), 32'(exp_val_c.size()));
    for (int i = 0; i < val_c.size() && i < exp_val_c.size(); i++) begin
      checkOutput($sformatf("%s val%0d cycle", name, i), 32'(val_c[i]), 32'(exp_val_c[i]));
      checkOutput($sformatf("%s val%0d value", name, i), 32'(val_v[i]), 32'(r.en));
    end
    checkOutput({name, " done count"}, 32'(done_c.size()), 32'd1);
    if (done_c.size() > 0) checkOutput({name, " done cycle"}, 32'(done_c[0]), 32'(exp_done));
    checkOutput({name, " timeout_err"}, 32'(timeout_err), 32'(exp_err));
    if (use_tbl) begin
      checkOutput({name, " tbl pulses"}, 32'(sel_c.size()), 32'(r.exp_pulses));
      checkOutput({name, " tbl err"}, 32'(timeout_err), 32'(r.exp_err));
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " select_test"}, 32'(select_test), 32'd0);
    checkOutput({name, " validate"}, 32'(validate), 32'd0);
    checkOutput({name, " iter_idx"}, 32'(iter_idx), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " run_done"}, 32'(run_done), 32'd0);
    checkOutput({name, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  run_t tbl [10];
  run_t r;
  int   rel, d;

  initial begin
    //             en     n     gap     tmo     dly       noise poke pulses err
    tbl[0] = '{4'hF, 8'd5, 8'd5,   16'd0,  16'h3333, 4'h0, 8'd0, 8'd5, 4'h0};
    tbl[1] = '{4'hF, 8'd1, 8'd0,   16'd0,  16'h4121, 4'h0, 8'd0, 8'd1, 4'h0};
    tbl[2] = '{4'h5, 8'd3, 8'd2,   16'd0,  16'hF1F2, 4'h2, 8'd0, 8'd3, 4'h0};
    tbl[3] = '{4'hF, 8'd3, 8'd1,   16'd10, 16'h2F22, 4'h0, 8'd3, 8'd3, 4'h4};
    tbl[4] = '{4'hF, 8'd2, 8'd0,   16'd5,  16'h1111, 4'h0, 8'd0, 8'd2, 4'h0};
    tbl[5] = '{4'hF, 8'd0, 8'd3,   16'd0,  16'h1111, 4'h0, 8'd1, 8'd0, 4'h0};
    tbl[6] = '{4'h0, 8'd3, 8'd3,   16'd0,  16'h1111, 4'h0, 8'd1, 8'd0, 4'h0};
    tbl[7] = '{4'h3, 8'd2, 8'd3,   16'd4,  16'hFF10, 4'h0, 8'd0, 8'd2, 4'h1};
    tbl[8] = '{4'h1, 8'd1, 8'd0,   16'd1,  16'hFFF1, 4'h0, 8'd0, 8'd1, 4'h1};
    tbl[9] = '{4'h8, 8'd1, 8'd255, 16'd0,  16'h2FFF, 4'h0, 8'd0, 8'd1, 4'h0};

    rst_n = 1'b0; start = 1'b0; ch_en = 4'h0; num_iter = 8'h0;
    gap_cycles = 8'h0; tmo_cycles = 16'h0; val_done = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(tbl[i], $sformatf("tbl%0d", i), 1'b1);

    // Reset asserted while the second iteration is still in its gap.
    r = '{4'hF, 8'd3, 8'd6, 16'd0, 16'h1111, 4'h0, 8'd0, 8'd0, 4'h0};
    startRun(r);
    @(posedge clk); #1;
    start = 1'b0;
    rel = cyc - base;
    while (rel < exp_sel_c[1] + 2) begin
      val_done = vd[rel];
      @(posedge clk); #1;
      rel = cyc - base;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkAllZero("midreset");
    rst_n = 1'b1;
    clearMon();
    repeat (40) begin
      val_done = 4'($urandom);
      @(posedge clk); #1;
    end
    mon_on = 1'b0;
    checkOutput("midreset sel after", 32'(sel_c.size()), 32'd0);
    checkOutput("midreset val after", 32'(val_c.size()), 32'd0);
    checkOutput("midreset done after", 32'(done_c.size()), 32'd0);
    checkOutput("midreset busy after", 32'(busy), 32'd0);
    val_done = 4'h0;

    for (int k = 0; k < 20; k++) begin
      r.en    = 4'($urandom);
      r.n     = 8'($urandom_range(0, 4));
      r.gap   = 8'($urandom_range(0, 5));
      r.tmo   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      r.noise = 4'($urandom);
      for (int ch = 0; ch < 4; ch++) begin
        if (r.tmo == 0) d = $urandom_range(1, 6);
        else begin
          d = $urandom_range(0, 7);
          if (d == 7) d = NEVER;
        end
        r.dly[ch*4 +: 4] = 4'(d);
      end
      r.poke = (r.n == 0 || r.en == 0) ? 8'd1 : 8'd3;
      r.exp_pulses = 8'd0;
      r.exp_err = 4'h0;
      applyStimulus(r, $sformatf("rnd%0d", k), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
